// File: rtl/run_len_pkg.sv
// rtl/run_len_pkg.sv - shared constants, record layout and tracker states for run_len_capture
package run_len_pkg;

    localparam int CNT_W_DEF = 8;
    localparam int DEPTH_DEF = 4;

    // Record layout at the default width; the top builds the same {sat, len} shape at its own CNT_W.
    typedef struct packed {
        logic                 sat;
        logic [CNT_W_DEF-1:0] len;
    } len_rec_t;

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_RUN  = 1'b1
    } trk_state_e;

    function automatic int rec_width(input int cnt_w);
        return cnt_w + 1;
    endfunction

endpackage

// File: rtl/run_len_fifo.sv
// rtl/run_len_fifo.sv - synchronous FIFO with separate occupancy counter
module run_len_fifo #(
    parameter int  WIDTH = 9,
    parameter int  DEPTH = 4,
    localparam int PTR_W = $clog2(DEPTH),
    localparam int LVL_W = PTR_W + 1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             push,
    input  logic [WIDTH-1:0] push_data,
    output logic             full,
    input  logic             pop,
    output logic [WIDTH-1:0] pop_data,
    output logic             empty,
    output logic [LVL_W-1:0] level
);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [WIDTH-1:0] mem_d [DEPTH];
    logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [LVL_W-1:0] level_q, level_d;
    logic             do_push;
    logic             do_pop;

    assign full     = (level_q == LVL_W'(DEPTH));
    assign empty    = (level_q == '0);
    assign level    = level_q;
    assign pop_data = mem_q[rd_ptr_q];

    // A pop in the same cycle frees the slot, so a push into a full FIFO still lands.
    always_comb begin
        mem_d    = mem_q;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        level_d  = level_q;
        do_pop   = pop && !empty;
        do_push  = push && (!full || do_pop);
        if (do_push) begin
            mem_d[wr_ptr_q] = push_data;
            wr_ptr_d        = wr_ptr_q + PTR_W'(1);
        end
        if (do_pop) begin
            rd_ptr_d = rd_ptr_q + PTR_W'(1);
        end
        case ({do_push, do_pop})
            2'b10:   level_d = level_q + LVL_W'(1);
            2'b01:   level_d = level_q - LVL_W'(1);
            default: level_d = level_q;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mem_q    <= '{default: '0};
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            level_q  <= '0;
        end else begin
            mem_q    <= mem_d;
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            level_q  <= level_d;
        end
    end

endmodule

// File: rtl/run_len_capture.sv
// rtl/run_len_capture.sv - measures r-strobe run lengths and queues one record per f pulse
module run_len_capture
    import run_len_pkg::*;
#(
    parameter int  CNT_W = CNT_W_DEF,
    parameter int  DEPTH = DEPTH_DEF,
    localparam int LVL_W = $clog2(DEPTH) + 1,
    localparam int REC_W = rec_width(CNT_W)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             r,
    input  logic             f,
    output logic             len_valid,
    input  logic             len_ready,
    output logic [CNT_W-1:0] len_data,
    output logic             len_sat,
    output logic             drop,
    output logic [LVL_W-1:0] level
);

    typedef struct packed {
        logic             sat;
        logic [CNT_W-1:0] len;
    } cap_rec_t;

    localparam logic [CNT_W-1:0] CNT_MAX = '1;

    trk_state_e       state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             sat_q, sat_d;
    logic             drop_q, drop_d;

    logic             push;
    cap_rec_t         push_rec;
    cap_rec_t         head_rec;
    logic             fifo_full;
    logic             fifo_empty;
    logic             pop;

    assign len_valid = !fifo_empty;
    assign pop       = len_valid && len_ready;
    assign len_data  = head_rec.len;
    assign len_sat   = head_rec.sat;
    assign drop      = drop_q;

    // f wins over r: a coincident r extends the closing run instead of opening a new one.
    always_comb begin
        state_d      = state_q;
        cnt_d        = cnt_q;
        sat_d        = sat_q;
        push         = 1'b0;
        push_rec.len = cnt_q;
        push_rec.sat = sat_q;
        if (f) begin
            push = 1'b1;
            if (r) begin
                if (cnt_q == CNT_MAX) begin
                    push_rec.sat = 1'b1;
                end else begin
                    push_rec.len = cnt_q + CNT_W'(1);
                end
            end
            state_d = ST_IDLE;
            cnt_d   = '0;
            sat_d   = 1'b0;
        end else if (r) begin
            case (state_q)
                ST_IDLE: begin
                    state_d = ST_RUN;
                    cnt_d   = CNT_W'(1);
                    sat_d   = 1'b0;
                end
                ST_RUN: begin
                    if (cnt_q == CNT_MAX) begin
                        sat_d = 1'b1;
                    end else begin
                        cnt_d = cnt_q + CNT_W'(1);
                    end
                end
                default: state_d = ST_IDLE;
            endcase
        end
        drop_d = push && fifo_full && !pop;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
            cnt_q   <= '0;
            sat_q   <= 1'b0;
            drop_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            sat_q   <= sat_d;
            drop_q  <= drop_d;
        end
    end

    run_len_fifo #(
        .WIDTH (REC_W),
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk       (clk),
        .rst_n     (rst_n),
        .push      (push),
        .push_data (push_rec),
        .full      (fifo_full),
        .pop       (pop),
        .pop_data  (head_rec),
        .empty     (fifo_empty),
        .level     (level)
    );

endmodule

// File: tb/tb_run_len_capture.sv
// tb/tb_run_len_capture.sv - self-checking bench for run_len_capture
module tb_run_len_capture;

    localparam int TB_CNT_W = 4;
    localparam int TB_DEPTH = 4;
    localparam int MAXV     = (1 << TB_CNT_W) - 1;

    logic                clk;
    logic                rst_n;
    logic                r;
    logic                f;
    logic                len_valid;
    logic                len_ready;
    logic [TB_CNT_W-1:0] len_data;
    logic                len_sat;
    logic                drop;
    logic [2:0]          level;

    run_len_capture #(
        .CNT_W (TB_CNT_W),
        .DEPTH (TB_DEPTH)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .r         (r),
        .f         (f),
        .len_valid (len_valid),
        .len_ready (len_ready),
        .len_data  (len_data),
        .len_sat   (len_sat),
        .drop      (drop),
        .level     (level)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        int len;
        bit sat;
    } rec_t;

    typedef struct {
        logic r;
        logic f;
        logic rdy;
        logic ev;
        int   ed;
        logic es;
        int   el;
        logic edr;
    } vec_t;

    rec_t mq[$];
    int   run_total;
    bit   m_drop;
    int   n_tests;
    int   n_fail;
    int   drop_seen;

    task automatic chk(input string name, input int act, input int exp);
        n_tests++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        mq.delete();
        run_total = 0;
        m_drop    = 1'b0;
    endtask

    task automatic check_model();
        chk("model_valid", int'(len_valid), int'(mq.size() != 0));
        chk("model_level", int'(level), mq.size());
        chk("model_drop", int'(drop), int'(m_drop));
        if (mq.size() != 0) begin
            chk("model_data", int'(len_data), mq[0].len);
            chk("model_sat", int'(len_sat), int'(mq[0].sat));
        end
    endtask

    // Drive one cycle, advance the reference queue, then sample just after the edge.
    task automatic apply(input logic ri, input logic fi, input logic rdyi);
        bit   do_pop;
        bit   accept;
        rec_t rec;
        r         = ri;
        f         = fi;
        len_ready = rdyi;
        @(posedge clk);
        do_pop = (mq.size() != 0) && rdyi;
        accept = 1'b0;
        m_drop = 1'b0;
        if (ri) run_total++;
        if (fi) begin
            rec.len   = (run_total > MAXV) ? MAXV : run_total;
            rec.sat   = (run_total > MAXV);
            run_total = 0;
            if (mq.size() < TB_DEPTH || do_pop) accept = 1'b1;
            else m_drop = 1'b1;
        end
        if (do_pop) void'(mq.pop_front());
        if (accept) mq.push_back(rec);
        #1;
        if (drop) drop_seen++;
        check_model();
    endtask

    task automatic run_of(input int n);
        for (int i = 0; i < n; i++) apply(1'b1, 1'b0, 1'b0);
        apply(1'b0, 1'b1, 1'b0);
    endtask

    vec_t tbl[15];

    initial begin
        n_tests   = 0;
        n_fail    = 0;
        drop_seen = 0;
        rst_n     = 1'b0;
        r         = 1'b0;
        f         = 1'b0;
        len_ready = 1'b0;
        model_reset();

        tbl[0]  = '{1'b1, 1'b0, 1'b0, 1'b0, 0, 1'b0, 0, 1'b0};
        tbl[1]  = '{1'b1, 1'b0, 1'b0, 1'b0, 0, 1'b0, 0, 1'b0};
        tbl[2]  = '{1'b1, 1'b0, 1'b0, 1'b0, 0, 1'b0, 0, 1'b0};
        tbl[3]  = '{1'b1, 1'b0, 1'b0, 1'b0, 0, 1'b0, 0, 1'b0};
        tbl[4]  = '{1'b1, 1'b0, 1'b0, 1'b0, 0, 1'b0, 0, 1'b0};
        tbl[5]  = '{1'b0, 1'b1, 1'b0, 1'b1, 5, 1'b0, 1, 1'b0};
        tbl[6]  = '{1'b0, 1'b0, 1'b1, 1'b0, 0, 1'b0, 0, 1'b0};
        tbl[7]  = '{1'b1, 1'b0, 1'b0, 1'b0, 0, 1'b0, 0, 1'b0};
        tbl[8]  = '{1'b1, 1'b0, 1'b0, 1'b0, 0, 1'b0, 0, 1'b0};
        tbl[9]  = '{1'b1, 1'b1, 1'b0, 1'b1, 3, 1'b0, 1, 1'b0};
        tbl[10] = '{1'b0, 1'b1, 1'b0, 1'b1, 3, 1'b0, 2, 1'b0};
        tbl[11] = '{1'b1, 1'b0, 1'b1, 1'b1, 0, 1'b0, 1, 1'b0};
        tbl[12] = '{1'b0, 1'b0, 1'b0, 1'b1, 0, 1'b0, 1, 1'b0};
        tbl[13] = '{1'b1, 1'b1, 1'b1, 1'b1, 2, 1'b0, 1, 1'b0};
        tbl[14] = '{1'b0, 1'b0, 1'b1, 1'b0, 0, 1'b0, 0, 1'b0};

        repeat (2) @(posedge clk);
        #1;
        chk("rst_valid", int'(len_valid), 0);
        chk("rst_level", int'(level), 0);
        chk("rst_drop", int'(drop), 0);
        chk("rst_data", int'(len_data), 0);
        chk("rst_sat", int'(len_sat), 0);
        @(negedge clk);
        rst_n = 1'b1;

        for (int i = 0; i < 15; i++) begin
            apply(tbl[i].r, tbl[i].f, tbl[i].rdy);
            chk($sformatf("tbl%0d_valid", i), int'(len_valid), int'(tbl[i].ev));
            chk($sformatf("tbl%0d_level", i), int'(level), tbl[i].el);
            chk($sformatf("tbl%0d_drop", i), int'(drop), int'(tbl[i].edr));
            if (tbl[i].ev) begin
                chk($sformatf("tbl%0d_data", i), int'(len_data), tbl[i].ed);
                chk($sformatf("tbl%0d_sat", i), int'(len_sat), int'(tbl[i].es));
            end
        end

        run_of(20);
        chk("sat_data", int'(len_data), 15);
        chk("sat_flag", int'(len_sat), 1);
        apply(1'b0, 1'b0, 1'b1);
        run_of(3);
        chk("post_sat_data", int'(len_data), 3);
        chk("post_sat_flag", int'(len_sat), 0);
        apply(1'b0, 1'b0, 1'b1);
        chk("post_sat_level", int'(level), 0);

        drop_seen = 0;
        for (int n = 1; n <= 5; n++) run_of(n);
        chk("full_level", int'(level), 4);
        apply(1'b0, 1'b0, 1'b0);
        chk("drop_count", drop_seen, 1);
        for (int i = 0; i < 4; i++) begin
            chk($sformatf("drain%0d", i), int'(len_data), i + 1);
            apply(1'b0, 1'b0, 1'b1);
        end
        chk("drained_level", int'(level), 0);

        drop_seen = 0;
        for (int n = 1; n <= 4; n++) run_of(n);
        for (int i = 0; i < 6; i++) apply(1'b1, 1'b0, 1'b0);
        apply(1'b0, 1'b1, 1'b1);
        chk("fullrdy_level", int'(level), 4);
        apply(1'b0, 1'b0, 1'b0);
        chk("fullrdy_nodrop", drop_seen, 0);
        for (int i = 0; i < 4; i++) begin
            chk($sformatf("fullrdy_drain%0d", i), int'(len_data), (i == 3) ? 6 : i + 2);
            apply(1'b0, 1'b0, 1'b1);
        end

        run_of(1);
        run_of(2);
        apply(1'b1, 1'b0, 1'b0);
        apply(1'b1, 1'b0, 1'b0);
        chk("pre_rst_level", int'(level), 2);
        #2;
        rst_n = 1'b0;
        #1;
        chk("async_rst_valid", int'(len_valid), 0);
        chk("async_rst_level", int'(level), 0);
        model_reset();
        @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        run_of(4);
        chk("post_rst_data", int'(len_data), 4);
        apply(1'b0, 1'b0, 1'b1);

        for (int i = 0; i < 4000; i++) begin
            logic ri;
            logic fi;
            logic rdyi;
            ri   = ($urandom_range(0, 99) < 65);
            fi   = ($urandom_range(0, 99) < 10);
            rdyi = ((i / 400) % 2 == 0) ? ($urandom_range(0, 99) < 70)
                                        : ($urandom_range(0, 99) < 15);
            apply(ri, fi, rdyi);
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
